// File: rtl/fpu_ss_wb_arbiter.sv
// Writeback responder for the FPU subsystem: merges FPU results and flw load data onto the
// single FPR write port, forwards integer-destination results to the core X interface.
module fpu_ss_wb_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fpu_out_valid_i,
  output logic              fpu_out_ready_o,
  input  logic [ADDR_W-1:0] fpu_waddr_i,
  input  logic [DATA_W-1:0] fpu_result_i,
  input  logic              fpu_rd_is_fpr_i,
  input  logic [ID_W-1:0]   fpu_id_i,
  input  logic              mem_result_valid_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              fpr_we_o,
  output logic [ADDR_W-1:0] fpr_waddr_o,
  output logic [DATA_W-1:0] fpr_wdata_o,
  output logic              x_result_valid_o,
  input  logic              x_result_ready_i,
  output logic [ADDR_W-1:0] x_result_rd_o,
  output logic [DATA_W-1:0] x_result_data_o,
  output logic [ID_W-1:0]   x_result_id_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  logic              hold_valid_q, hold_valid_d;
  logic              hold_fpr_q,   hold_fpr_d;
  logic [ADDR_W-1:0] hold_addr_q,  hold_addr_d;
  logic [DATA_W-1:0] hold_data_q,  hold_data_d;
  logic [ID_W-1:0]   hold_id_q,    hold_id_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;

  logic load_wr;
  logic drain;
  logic capture;
  logic conflict;

  always_comb begin
    load_wr  = mem_result_valid_i && mem_we_i;
    drain    = hold_valid_q && (hold_fpr_q ? !load_wr : x_result_ready_i);
    fpu_out_ready_o = !hold_valid_q || drain;
    capture  = fpu_out_valid_i && fpu_out_ready_o;
    conflict = hold_valid_q && hold_fpr_q && load_wr;
  end

  // Capture takes precedence over drain so a same-cycle drain+capture keeps the entry valid.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_fpr_d   = hold_fpr_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    hold_id_d    = hold_id_q;
    if (capture) begin
      hold_valid_d = 1'b1;
      hold_fpr_d   = fpu_rd_is_fpr_i;
      hold_addr_d  = fpu_waddr_i;
      hold_data_d  = fpu_result_i;
      hold_id_d    = fpu_id_i;
    end else if (drain) begin
      hold_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_fpr_q   <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_id_q    <= '0;
      cnt_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_fpr_q   <= hold_fpr_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      hold_id_q    <= hold_id_d;
      cnt_q        <= cnt_d;
    end
  end

  // Loads cannot be back-pressured, so they always win the FPR port.
  always_comb begin
    fpr_we_o    = 1'b0;
    fpr_waddr_o = hold_addr_q;
    fpr_wdata_o = hold_data_q;
    if (load_wr) begin
      fpr_we_o    = 1'b1;
      fpr_waddr_o = mem_waddr_i;
      fpr_wdata_o = mem_rdata_i;
    end else if (hold_valid_q && hold_fpr_q) begin
      fpr_we_o    = 1'b1;
    end
  end

  always_comb begin
    x_result_valid_o = hold_valid_q && !hold_fpr_q;
    x_result_rd_o    = hold_addr_q;
    x_result_data_o  = hold_data_q;
    x_result_id_o    = hold_id_q;
    conflict_cnt_o   = cnt_q;
  end

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed bench for fpu_ss_wb_arbiter; a second CNT_W=4 instance shares the stimulus
// to exercise counter saturation.
module tb_fpu_ss_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fpu_valid;
  logic [4:0]  fpu_waddr;
  logic [31:0] fpu_result;
  logic        fpu_fpr;
  logic [3:0]  fpu_id;
  logic        mem_valid;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_rdata;
  logic        x_ready;

  logic        ready, fpr_we, x_valid;
  logic [4:0]  fpr_waddr, x_rd;
  logic [31:0] fpr_wdata, x_data;
  logic [3:0]  x_id;
  logic [15:0] cnt;

  logic        s_ready, s_fpr_we, s_x_valid;
  logic [4:0]  s_fpr_waddr, s_x_rd;
  logic [31:0] s_fpr_wdata, s_x_data;
  logic [3:0]  s_x_id;
  logic [3:0]  s_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  fpu_ss_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .ID_W(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .fpu_out_valid_i(fpu_valid), .fpu_out_ready_o(ready),
    .fpu_waddr_i(fpu_waddr), .fpu_result_i(fpu_result),
    .fpu_rd_is_fpr_i(fpu_fpr), .fpu_id_i(fpu_id),
    .mem_result_valid_i(mem_valid), .mem_we_i(mem_we),
    .mem_waddr_i(mem_waddr), .mem_rdata_i(mem_rdata),
    .fpr_we_o(fpr_we), .fpr_waddr_o(fpr_waddr), .fpr_wdata_o(fpr_wdata),
    .x_result_valid_o(x_valid), .x_result_ready_i(x_ready),
    .x_result_rd_o(x_rd), .x_result_data_o(x_data), .x_result_id_o(x_id),
    .conflict_cnt_o(cnt)
  );

  fpu_ss_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .ID_W(4), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .fpu_out_valid_i(fpu_valid), .fpu_out_ready_o(s_ready),
    .fpu_waddr_i(fpu_waddr), .fpu_result_i(fpu_result),
    .fpu_rd_is_fpr_i(fpu_fpr), .fpu_id_i(fpu_id),
    .mem_result_valid_i(mem_valid), .mem_we_i(mem_we),
    .mem_waddr_i(mem_waddr), .mem_rdata_i(mem_rdata),
    .fpr_we_o(s_fpr_we), .fpr_waddr_o(s_fpr_waddr), .fpr_wdata_o(s_fpr_wdata),
    .x_result_valid_o(s_x_valid), .x_result_ready_i(x_ready),
    .x_result_rd_o(s_x_rd), .x_result_data_o(s_x_data), .x_result_id_o(s_x_id),
    .conflict_cnt_o(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic fpu_drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                           input logic fpr, input logic [3:0] id);
    fpu_valid = v; fpu_waddr = a; fpu_result = d; fpu_fpr = fpr; fpu_id = id;
  endtask

  task automatic mem_drive(input logic v, input logic we, input logic [4:0] a,
                           input logic [31:0] d);
    mem_valid = v; mem_we = we; mem_waddr = a; mem_rdata = d;
  endtask

  initial begin
    rst = 1'b1;
    x_ready = 1'b1;
    fpu_drive(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    settle();

    check("rst_ready",   32'(ready),     32'd1);
    check("rst_fpr_we",  32'(fpr_we),    32'd0);
    check("rst_x_valid", 32'(x_valid),   32'd0);
    check("rst_cnt",     32'(cnt),       32'd0);
    check("rst_waddr",   32'(fpr_waddr), 32'd0);
    check("rst_wdata",   fpr_wdata,      32'd0);
    check("rst_x_rd",    32'(x_rd),      32'd0);
    check("rst_x_data",  x_data,         32'd0);
    check("rst_x_id",    32'(x_id),      32'd0);

    // FPU -> FPR path
    tick();
    fpu_drive(1'b1, 5'd3, 32'h40490FDB, 1'b1, 4'd1);
    settle();
    check("p1_ready_n",  32'(ready),  32'd1);
    check("p1_we_n",     32'(fpr_we), 32'd0);
    tick();
    fpu_drive(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    settle();
    check("p1_we",    32'(fpr_we),    32'd1);
    check("p1_waddr", 32'(fpr_waddr), 32'd3);
    check("p1_wdata", fpr_wdata,      32'h40490FDB);
    check("p1_cnt",   32'(cnt),       32'd0);
    tick();
    check("p1_idle_we", 32'(fpr_we), 32'd0);

    // Load conflict with held FPR result
    fpu_drive(1'b1, 5'd5, 32'h3F800000, 1'b1, 4'd2);
    tick();
    fpu_drive(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    mem_drive(1'b1, 1'b1, 5'd5, 32'h40000000);
    settle();
    check("p2_ld_we",    32'(fpr_we),    32'd1);
    check("p2_ld_waddr", 32'(fpr_waddr), 32'd5);
    check("p2_ld_wdata", fpr_wdata,      32'h40000000);
    check("p2_ready",    32'(ready),     32'd0);
    tick();
    mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
    settle();
    check("p2_cnt",      32'(cnt),       32'd1);
    check("p2_fpu_we",   32'(fpr_we),    32'd1);
    check("p2_fpu_addr", 32'(fpr_waddr), 32'd5);
    check("p2_fpu_data", fpr_wdata,      32'h3F800000);
    tick();
    check("p2_idle_we", 32'(fpr_we), 32'd0);

    // X back-pressure
    x_ready = 1'b0;
    fpu_drive(1'b1, 5'd10, 32'h0000002A, 1'b0, 4'd7);
    tick();
    fpu_drive(1'b1, 5'd11, 32'h00000055, 1'b0, 4'd8);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("p3_x_valid", 32'(x_valid), 32'd1);
      check("p3_x_rd",    32'(x_rd),    32'd10);
      check("p3_x_data",  x_data,       32'h2A);
      check("p3_x_id",    32'(x_id),    32'd7);
      check("p3_ready",   32'(ready),   32'd0);
      check("p3_fpr_we",  32'(fpr_we),  32'd0);
      tick();
    end
    x_ready = 1'b1;
    settle();
    check("p3_rel_x_rd",  32'(x_rd),  32'd10);
    check("p3_rel_ready", 32'(ready), 32'd1);
    tick();
    fpu_drive(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    settle();
    check("p3_x2_valid", 32'(x_valid), 32'd1);
    check("p3_x2_rd",    32'(x_rd),    32'd11);
    check("p3_x2_data",  x_data,       32'h55);
    check("p3_x2_id",    32'(x_id),    32'd8);
    tick();
    check("p3_x_idle", 32'(x_valid), 32'd0);

    // Store completion concurrent with held FPR result
    fpu_drive(1'b1, 5'd7, 32'h11223344, 1'b1, 4'd3);
    tick();
    fpu_drive(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    mem_drive(1'b1, 1'b0, 5'd7, 32'h0000DEAD);
    settle();
    check("p4_we",    32'(fpr_we),    32'd1);
    check("p4_waddr", 32'(fpr_waddr), 32'd7);
    check("p4_wdata", fpr_wdata,      32'h11223344);
    check("p4_ready", 32'(ready),     32'd1);
    tick();
    mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
    settle();
    check("p4_cnt",     32'(cnt),    32'd1);
    check("p4_idle_we", 32'(fpr_we), 32'd0);

    // Reset while an X result is held
    x_ready = 1'b0;
    fpu_drive(1'b1, 5'd12, 32'h00000099, 1'b0, 4'd9);
    tick();
    fpu_drive(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    check("p5_held", 32'(x_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("p5_x_valid", 32'(x_valid), 32'd0);
    check("p5_cnt",     32'(cnt),     32'd0);
    check("p5_ready",   32'(ready),   32'd1);
    x_ready = 1'b1;
    tick();
    check("p5_no_x",  32'(x_valid), 32'd0);
    check("p5_no_we", 32'(fpr_we),  32'd0);

    // Counter saturation: hold an FPR result and keep loading for 20 cycles
    fpu_drive(1'b1, 5'd1, 32'hCAFEF00D, 1'b1, 4'd4);
    tick();
    fpu_drive(1'b0, 5'd0, 32'h0, 1'b0, 4'd0);
    mem_drive(1'b1, 1'b1, 5'd2, 32'h12345678);
    for (int i = 0; i < 20; i++) begin
      if (i == 14) begin
        settle();
        check("p6_sat_mid", 32'(s_cnt), 32'd14);
        check("p6_big_mid", 32'(cnt),   32'd14);
      end
      tick();
    end
    mem_drive(1'b0, 1'b0, 5'd0, 32'h0);
    settle();
    check("p6_sat_cnt", 32'(s_cnt),     32'hF);
    check("p6_big_cnt", 32'(cnt),       32'd20);
    check("p6_we",      32'(fpr_we),    32'd1);
    check("p6_waddr",   32'(fpr_waddr), 32'd1);
    check("p6_wdata",   fpr_wdata,      32'hCAFEF00D);
    tick();
    check("p6_sat_hold", 32'(s_cnt), 32'hF);
    check("p6_idle_we",  32'(fpr_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
